// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module : fetch_stage_pkg
// Purpose: Shared types and constants for the instruction fetch stage:
//          word width, default instruction memory depth, FSM state encoding
//          and a PC range helper.
// Ports  : none (package)
// Rev    : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

  localparam int WORD_W             = 32;
  localparam int IMEM_DEPTH_DEFAULT = 1024;

  typedef logic [WORD_W-1:0] word_t;

  // Fetch FSM encoding
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  // True when a word address lies inside the instruction memory.
  function automatic logic pc_in_range(input word_t pc, input int unsigned depth);
    return pc < word_t'(depth);
  endfunction

endpackage : fetch_stage_pkg
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module : fetch_stage_if
// Purpose: Bundles the instruction-memory, pipeline-control and IF/ID
//          signals of the fetch stage. Names carry the direction as seen
//          from the fetch stage (i_ = into fetch, o_ = out of fetch).
// Ports  : none; modports
//          master - fetch stage side
//          slave  - memory / decode / execute side
// Rev    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  word_t o_imem_addr;
  word_t i_imem_instr;
  logic  i_stall;
  logic  i_redirect;
  word_t i_redirect_pc;
  logic  i_halt_req;
  word_t o_ifid_instr;
  word_t o_ifid_pc1;
  logic  o_ifid_valid;
  logic  o_fetch_fault;
  logic  o_halted;

  modport master (
    output o_imem_addr,
    input  i_imem_instr,
    input  i_stall,
    input  i_redirect,
    input  i_redirect_pc,
    input  i_halt_req,
    output o_ifid_instr,
    output o_ifid_pc1,
    output o_ifid_valid,
    output o_fetch_fault,
    output o_halted
  );

  modport slave (
    input  o_imem_addr,
    output i_imem_instr,
    output i_stall,
    output i_redirect,
    output i_redirect_pc,
    output i_halt_req,
    input  o_ifid_instr,
    input  o_ifid_pc1,
    input  o_ifid_valid,
    input  o_fetch_fault,
    input  o_halted
  );

endinterface : fetch_stage_if
`default_nettype wire

// File: rtl/fetch_stage_pc_register.sv
`default_nettype none
// ============================================================================
// Module : fetch_stage_pc_register
// Purpose: Program counter flop with load, hold and increment. Load has
//          priority over hold; otherwise the PC advances by one word
//          (32-bit modulo).
// Ports  : clk       - clock
//          rst_n     - asynchronous active-low reset (PC <= RESET_PC)
//          i_load    - load i_load_pc
//          i_load_pc - load target
//          i_hold    - keep current PC
//          o_pc      - current PC
//          o_pc1     - PC + 1
// Rev    : 1.0 - initial release
// ============================================================================
module fetch_stage_pc_register
  import fetch_stage_pkg::*;
#(
  parameter word_t RESET_PC = 32'd0
) (
  input  wire   clk,
  input  wire   rst_n,
  input  wire   i_load,
  input  word_t i_load_pc,
  input  wire   i_hold,
  output word_t o_pc,
  output word_t o_pc1
);

  word_t r_pc;
  word_t w_pc1;

  // Natural wrap from 32'hFFFFFFFF to 0
  assign w_pc1 = r_pc + word_t'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_load_pc;
    end else if (!i_hold) begin
      r_pc <= w_pc1;
    end
  end

  assign o_pc  = r_pc;
  assign o_pc1 = w_pc1;

endmodule : fetch_stage_pc_register
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module : fetch_stage
// Purpose: Instruction fetch stage. Presents the PC to an external
//          combinational instruction memory, captures the returned word in
//          the IF/ID register one cycle later, and handles stall, redirect
//          (flush), out-of-range fault and halt.
// Ports  : clk   - clock
//          rst_n - asynchronous active-low reset
//          bus   - fetch_stage_if.master (memory, control, IF/ID outputs)
// Rev    : 1.0 - initial release
// ============================================================================
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter word_t RESET_PC   = 32'd0,
  parameter int    IMEM_DEPTH = IMEM_DEPTH_DEFAULT
) (
  input  wire           clk,
  input  wire           rst_n,
  fetch_stage_if.master bus
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;

  word_t w_pc;
  word_t w_pc1;
  logic  w_pc_hold;
  logic  w_pc_load;
  logic  w_ifid_load;
  logic  w_ifid_bubble;
  logic  w_fault_set;
  logic  w_in_range;

  word_t r_ifid_instr;
  word_t r_ifid_pc1;
  logic  r_ifid_valid;
  logic  r_fetch_fault;

  fetch_stage_pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_pc_load),
    .i_load_pc (bus.i_redirect_pc),
    .i_hold    (w_pc_hold),
    .o_pc      (w_pc),
    .o_pc1     (w_pc1)
  );

  assign w_in_range = pc_in_range(w_pc, IMEM_DEPTH);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      // Halt is only taken on a cycle that actually fetches: a redirect
      // or a stall defers it.
      ST_RUN:  if (!bus.i_redirect && !bus.i_stall && bus.i_halt_req) begin
                 w_state_nxt = ST_HALT;
               end
      ST_HALT: w_state_nxt = ST_HALT;
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_pc_hold     = 1'b1;
    w_pc_load     = 1'b0;
    w_ifid_load   = 1'b0;
    w_ifid_bubble = 1'b0;
    w_fault_set   = 1'b0;
    case (r_state)
      ST_BOOT: w_ifid_bubble = 1'b1;
      ST_RUN: begin
        if (bus.i_redirect) begin
          // Redirect beats stall and flushes the instruction in flight
          w_pc_load     = 1'b1;
          w_pc_hold     = 1'b0;
          w_ifid_bubble = 1'b1;
        end else if (!bus.i_stall) begin
          w_pc_hold = 1'b0;
          if (w_in_range) begin
            w_ifid_load = 1'b1;
          end else begin
            // Out-of-range fetch: record it, insert a bubble, keep going
            w_ifid_bubble = 1'b1;
            w_fault_set   = 1'b1;
          end
        end
      end
      ST_HALT: w_ifid_bubble = 1'b1;
      default: w_ifid_bubble = 1'b1;
    endcase
  end

  // ---------------- IF/ID register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ifid_instr <= '0;
      r_ifid_pc1   <= '0;
      r_ifid_valid <= 1'b0;
    end else if (w_ifid_load) begin
      r_ifid_instr <= bus.i_imem_instr;
      r_ifid_pc1   <= w_pc1;
      r_ifid_valid <= 1'b1;
    end else if (w_ifid_bubble) begin
      r_ifid_valid <= 1'b0;
    end
  end

  // Sticky until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_fault <= 1'b0;
    end else if (w_fault_set) begin
      r_fetch_fault <= 1'b1;
    end
  end

  assign bus.o_imem_addr   = w_pc;
  assign bus.o_ifid_instr  = r_ifid_instr;
  assign bus.o_ifid_pc1    = r_ifid_pc1;
  assign bus.o_ifid_valid  = r_ifid_valid;
  assign bus.o_fetch_fault = r_fetch_fault;
  assign bus.o_halted      = (r_state == ST_HALT);

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_fetch_stage
// Purpose: Directed self-checking bench for fetch_stage with a
//          combinational instruction memory model (word(a) = A5000000 + a).
// Ports  : none
// Rev    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC   (32'd0),
    .IMEM_DEPTH (1024)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic word_t word_of(input word_t a);
    return 32'hA500_0000 + a;
  endfunction

  assign bus.i_imem_instr = word_of(bus.o_imem_addr);

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input word_t instr, input word_t pc1);
    chk({tag, "_valid"}, word_t'(bus.o_ifid_valid), 32'd1);
    chk({tag, "_instr"}, bus.o_ifid_instr, instr);
    chk({tag, "_pc1"},   bus.o_ifid_pc1,   pc1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.i_stall       = 1'b0;
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = '0;
    bus.i_halt_req    = 1'b0;
    rst_n             = 1'b0;

    // Reset state
    #12;
    chk("rst_addr",   bus.o_imem_addr, 32'd0);
    chk("rst_valid",  word_t'(bus.o_ifid_valid), 32'd0);
    chk("rst_instr",  bus.o_ifid_instr, 32'd0);
    chk("rst_pc1",    bus.o_ifid_pc1, 32'd0);
    chk("rst_fault",  word_t'(bus.o_fetch_fault), 32'd0);
    chk("rst_halted", word_t'(bus.o_halted), 32'd0);

    // Release away from the edge; BOOT gives one bubble
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    chk("boot_valid", word_t'(bus.o_ifid_valid), 32'd0);
    chk("boot_addr",  bus.o_imem_addr, 32'd0);

    // Words 0..3 stream out
    for (int i = 0; i < 4; i++) begin
      step();
      chk_ifid("seq", word_of(word_t'(i)), word_t'(i + 1));
    end
    step();
    chk_ifid("seq4", word_of(32'd4), 32'd5);
    chk("pc5", bus.o_imem_addr, 32'd5);

    // Stall three cycles at PC=5
    bus.i_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_addr", bus.o_imem_addr, 32'd5);
      chk_ifid("stall", word_of(32'd4), 32'd5);
    end
    bus.i_stall = 1'b0;
    step();
    chk_ifid("resume", word_of(32'd5), 32'd6);
    chk("resume_addr", bus.o_imem_addr, 32'd6);
    step();
    chk("pc7", bus.o_imem_addr, 32'd7);

    // Redirect with stall at PC=7: redirect wins
    bus.i_stall       = 1'b1;
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'd3;
    step();
    chk("redir_valid", word_t'(bus.o_ifid_valid), 32'd0);
    chk("redir_addr",  bus.o_imem_addr, 32'd3);
    bus.i_stall    = 1'b0;
    bus.i_redirect = 1'b0;
    step();
    chk_ifid("redir_fetch", word_of(32'd3), 32'd4);

    // Top of memory and fault
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'd1023;
    step();
    bus.i_redirect = 1'b0;
    chk("top_addr", bus.o_imem_addr, 32'd1023);
    step();
    chk_ifid("w1023", word_of(32'd1023), 32'd1024);
    chk("no_fault_yet", word_t'(bus.o_fetch_fault), 32'd0);
    step();
    chk("fault_set",    word_t'(bus.o_fetch_fault), 32'd1);
    chk("fault_bubble", word_t'(bus.o_ifid_valid), 32'd0);
    chk("fault_adv",    bus.o_imem_addr, 32'd1025);
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'd0;
    step();
    bus.i_redirect = 1'b0;
    step();
    chk_ifid("recover", word_of(32'd0), 32'd1);
    chk("fault_sticky", word_t'(bus.o_fetch_fault), 32'd1);

    // Asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_fault", word_t'(bus.o_fetch_fault), 32'd0);
    chk("arst_valid", word_t'(bus.o_ifid_valid), 32'd0);
    chk("arst_addr",  bus.o_imem_addr, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    step();
    chk_ifid("rst2_w0", word_of(32'd0), 32'd1);

    // PC wrap from FFFFFFFF
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'hFFFF_FFFF;
    step();
    bus.i_redirect = 1'b0;
    chk("wrap_pre", bus.o_imem_addr, 32'hFFFF_FFFF);
    step();
    chk("wrap_addr",  bus.o_imem_addr, 32'd0);
    chk("wrap_fault", word_t'(bus.o_fetch_fault), 32'd1);
    chk("wrap_valid", word_t'(bus.o_ifid_valid), 32'd0);
    step();
    step();
    step();
    chk_ifid("w2", word_of(32'd2), 32'd3);

    // Redirect together with halt_req: stay in RUN
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'd3;
    bus.i_halt_req    = 1'b1;
    step();
    chk("rh_halted", word_t'(bus.o_halted), 32'd0);
    chk("rh_addr",   bus.o_imem_addr, 32'd3);
    bus.i_redirect = 1'b0;
    bus.i_halt_req = 1'b0;
    step();
    chk_ifid("w3", word_of(32'd3), 32'd4);

    // halt_req under stall waits for stall to drop
    bus.i_stall    = 1'b1;
    bus.i_halt_req = 1'b1;
    step();
    chk("sh_halted", word_t'(bus.o_halted), 32'd0);
    chk("sh_addr",   bus.o_imem_addr, 32'd4);
    bus.i_stall = 1'b0;
    step();
    chk_ifid("halt_w4", word_of(32'd4), 32'd5);
    chk("halt_on",  word_t'(bus.o_halted), 32'd1);
    chk("halt_pc",  bus.o_imem_addr, 32'd5);
    bus.i_halt_req    = 1'b0;
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'd9;
    step();
    chk("halt_bubble", word_t'(bus.o_ifid_valid), 32'd0);
    chk("halt_hold",   bus.o_imem_addr, 32'd5);
    chk("halt_stay",   word_t'(bus.o_halted), 32'd1);
    bus.i_redirect = 1'b0;

    // Reset out of HALT
    #2;
    rst_n = 1'b0;
    #1;
    chk("hrst_halted", word_t'(bus.o_halted), 32'd0);
    chk("hrst_addr",   bus.o_imem_addr, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    chk("hrst_boot", word_t'(bus.o_ifid_valid), 32'd0);
    step();
    chk_ifid("hrst_w0", word_of(32'd0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fetch_stage
`default_nettype wire
